// File: rtl/alu_pkg.sv
// Shared datapath constants for the ALU, decoder and register file / PSR stage.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int FLAG_W = 5;

  // PSR bit positions, ZCFNL order from MSB down.
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  localparam logic [FLAG_W-1:0] MASK_ZONLY = 5'b10000;
  localparam logic [FLAG_W-1:0] MASK_ALL   = 5'b11111;
  localparam logic [FLAG_W-1:0] MASK_NL    = 5'b00011;

  function automatic logic [FLAG_W-1:0] apply_mask(input logic [FLAG_W-1:0] old_flags,
                                                   input logic [FLAG_W-1:0] new_flags,
                                                   input logic [FLAG_W-1:0] mask);
    return (old_flags & ~mask) | (new_flags & mask);
  endfunction

endpackage

// File: rtl/alu_regfile_psr_psr_reg.sv
// psr_reg: masked flag register with asynchronous active-low reset.
// Only bits selected by mask_i are updated when we_i is high.
module psr_reg
  import alu_pkg::*;
#(
  parameter int W = FLAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we_i,
  input  logic [W-1:0] mask_i,
  input  logic [W-1:0] flags_i,
  output logic [W-1:0] psr_o
);

  logic [W-1:0] flags_q;
  logic [W-1:0] flags_d;

  always_comb begin
    flags_d = flags_q;
    if (we_i) begin
      flags_d = (flags_q & ~mask_i) | (flags_i & mask_i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign psr_o = flags_q;

endmodule

// File: rtl/alu_regfile_psr.sv
// Register file (16 x 16-bit GPRs) plus PSR around the ALU, with a write counter.
// Optional same-cycle write-to-read forwarding when ALU_REGFILE_BYPASS_EN is defined.
module alu_regfile_psr
  import alu_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = ADDR_W,
  parameter int FLAG_W_P = FLAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W_P-1:0] rd_addr_a,
  input  logic [ADDR_W_P-1:0] rd_addr_b,
  output logic [DATA_W_P-1:0] rd_data_a,
  output logic [DATA_W_P-1:0] rd_data_b,
  input  logic                wb_we,
  input  logic [ADDR_W_P-1:0] wb_addr,
  input  logic [DATA_W_P-1:0] wb_data,
  input  logic                wb_flag_we,
  input  logic [FLAG_W_P-1:0] wb_flag_mask,
  input  logic [FLAG_W_P-1:0] wb_flags,
  output logic [FLAG_W_P-1:0] psr,
  output logic [15:0]         wb_count
);

  localparam int DEPTH = 2 ** ADDR_W_P;

  logic [DATA_W_P-1:0] gpr_q [DEPTH];
  logic [DATA_W_P-1:0] gpr_d [DEPTH];
  logic [15:0]         count_q;
  logic [15:0]         count_d;

  // wb_addr is only used under wb_we, so an unknown address while idle never reaches state.
  always_comb begin
    gpr_d   = gpr_q;
    count_d = count_q;
    if (wb_we) begin
      gpr_d[wb_addr] = wb_data;
      count_d        = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        gpr_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      gpr_q   <= gpr_d;
      count_q <= count_d;
    end
  end

`ifdef ALU_REGFILE_BYPASS_EN
  // Forwarding is gated by rst_n so reads still return zero while reset is held.
  always_comb begin
    rd_data_a = gpr_q[rd_addr_a];
    rd_data_b = gpr_q[rd_addr_b];
    if (rst_n && wb_we && (rd_addr_a == wb_addr)) begin
      rd_data_a = wb_data;
    end
    if (rst_n && wb_we && (rd_addr_b == wb_addr)) begin
      rd_data_b = wb_data;
    end
  end
`else
  assign rd_data_a = gpr_q[rd_addr_a];
  assign rd_data_b = gpr_q[rd_addr_b];
`endif

  psr_reg #(
    .W(FLAG_W_P)
  ) u_psr (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (wb_flag_we),
    .mask_i (wb_flag_mask),
    .flags_i(wb_flags),
    .psr_o  (psr)
  );

  assign wb_count = count_q;

endmodule

// File: tb/tb_alu_regfile_psr.sv
// Directed self-checking bench for alu_regfile_psr using an expectation queue.
module tb_alu_regfile_psr;
  import alu_pkg::*;

  localparam int SEL_A   = 0;
  localparam int SEL_B   = 1;
  localparam int SEL_PSR = 2;
  localparam int SEL_CNT = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_flag_we;
  logic [FLAG_W-1:0] wb_flag_mask;
  logic [FLAG_W-1:0] wb_flags;
  logic [FLAG_W-1:0] psr;
  logic [15:0]       wb_count;

  exp_t scoreboard[$];
  int   compared   = 0;
  int   mismatched = 0;

  alu_regfile_psr dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_flag_we  (wb_flag_we),
    .wb_flag_mask(wb_flag_mask),
    .wb_flags    (wb_flags),
    .psr         (psr),
    .wb_count    (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input string tag, input int sel, input logic [15:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    #1;
    while (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      case (e.sel)
        SEL_A:   obs = rd_data_a;
        SEL_B:   obs = rd_data_b;
        SEL_PSR: obs = {11'd0, psr};
        default: obs = wb_count;
      endcase
      compared++;
      assert (obs === e.exp) else begin
        mismatched++;
        $error("[TB] FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    wb_we        = 1'b0;
    wb_addr      = '0;
    wb_data      = '0;
    wb_flag_we   = 1'b0;
    wb_flag_mask = '0;
    wb_flags     = '0;

    repeat (2) @(posedge clk);
    applyStimulus("reset_rd_a", SEL_A, 16'h0000);
    applyStimulus("reset_psr", SEL_PSR, 16'h0000);
    applyStimulus("reset_cnt", SEL_CNT, 16'h0000);
    checkOutput();
    rst_n = 1'b1;

    // Consecutive writes to R5 and R15, then dual read.
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 16'h1234;
    nextEdge();
    wb_addr = 4'd15; wb_data = 16'hFFFF;
    nextEdge();
    wb_we = 1'b0; rd_addr_a = 4'd5; rd_addr_b = 4'd15;
    applyStimulus("wr_rd_a_r5", SEL_A, 16'h1234);
    applyStimulus("wr_rd_b_r15", SEL_B, 16'hFFFF);
    applyStimulus("wr_cnt2", SEL_CNT, 16'd2);
    checkOutput();

    // Same-address read during a write.
    wb_we = 1'b1; wb_addr = 4'd7; wb_data = 16'h0001;
    nextEdge();
    wb_data = 16'h00AA; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
`ifdef ALU_REGFILE_BYPASS_EN
    applyStimulus("hazard_a", SEL_A, 16'h00AA);
    applyStimulus("hazard_b", SEL_B, 16'h00AA);
`else
    applyStimulus("hazard_a", SEL_A, 16'h0001);
    applyStimulus("hazard_b", SEL_B, 16'h0001);
`endif
    checkOutput();
    @(posedge clk); #1;
    wb_we = 1'b0;
    applyStimulus("hazard_after", SEL_A, 16'h00AA);
    applyStimulus("hazard_cnt", SEL_CNT, 16'd4);
    checkOutput();

    // Masked PSR updates.
    wb_flag_we = 1'b1; wb_flag_mask = MASK_ALL; wb_flags = 5'b11111;
    nextEdge();
    applyStimulus("psr_all_ones", SEL_PSR, 16'h001F);
    checkOutput();
    wb_flag_mask = MASK_NL; wb_flags = 5'b00000;
    nextEdge();
    applyStimulus("psr_mask_nl", SEL_PSR, 16'h001C);
    checkOutput();
    wb_flag_we = 1'b0; wb_flags = 5'b00011;
    nextEdge();
    applyStimulus("psr_we_off", SEL_PSR, 16'h001C);
    checkOutput();
    wb_flag_we = 1'b1; wb_flag_mask = 5'b00000; wb_flags = 5'b00011;
    nextEdge();
    applyStimulus("psr_mask_zero", SEL_PSR, 16'h001C);
    checkOutput();

    // Flag-only write leaves GPRs and counter alone.
    wb_flag_mask = MASK_ALL; wb_flags = 5'b10000;
    nextEdge();
    applyStimulus("flag_only_psr", SEL_PSR, 16'h0010);
    applyStimulus("flag_only_gpr", SEL_A, 16'h00AA);
    applyStimulus("flag_only_cnt", SEL_CNT, 16'd4);
    checkOutput();
    wb_flag_mask = MASK_ZONLY; wb_flags = 5'b00000;
    nextEdge();
    wb_flag_we = 1'b0;
    applyStimulus("psr_zonly", SEL_PSR, 16'h0000);
    checkOutput();
    wb_flag_we = 1'b1; wb_flag_mask = MASK_ALL; wb_flags = 5'b01010;
    nextEdge();
    wb_flag_we = 1'b0;

    // Async reset mid-cycle wins over a pending write.
    wb_we = 1'b1; wb_addr = 4'd3; wb_data = 16'hBEEF; rd_addr_b = 4'd3;
    nextEdge();
    wb_we = 1'b0;
    applyStimulus("pre_reset_r3", SEL_B, 16'hBEEF);
    applyStimulus("pre_reset_psr", SEL_PSR, 16'h000A);
    checkOutput();
    wb_we = 1'b1; wb_data = 16'h1111; rd_addr_a = 4'd3;
    #2;
    rst_n = 1'b0;
    applyStimulus("async_rst_a", SEL_A, 16'h0000);
    applyStimulus("async_rst_psr", SEL_PSR, 16'h0000);
    applyStimulus("async_rst_cnt", SEL_CNT, 16'h0000);
    checkOutput();
    nextEdge();
    applyStimulus("rst_held_b", SEL_B, 16'h0000);
    applyStimulus("rst_held_cnt", SEL_CNT, 16'h0000);
    checkOutput();

    // First write after release lands on the next edge.
    rst_n = 1'b1; wb_we = 1'b1; wb_addr = 4'd1; wb_data = 16'h0042;
    nextEdge();
    wb_we = 1'b0; rd_addr_a = 4'd1; rd_addr_b = 4'd3;
    applyStimulus("first_wr_r1", SEL_A, 16'h0042);
    applyStimulus("first_wr_r3", SEL_B, 16'h0000);
    applyStimulus("first_wr_cnt", SEL_CNT, 16'd1);
    checkOutput();

    // Drive the counter to its top value, then wrap with a write to R0.
    wb_we = 1'b1; wb_addr = 4'd2; wb_data = 16'h0F0F;
    repeat (65534) @(posedge clk);
    #1;
    wb_we = 1'b0;
    applyStimulus("cnt_top", SEL_CNT, 16'hFFFF);
    checkOutput();
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 16'h5555;
    nextEdge();
    wb_we = 1'b0; rd_addr_a = 4'd0; rd_addr_b = 4'd2;
    applyStimulus("cnt_wrap", SEL_CNT, 16'h0000);
    applyStimulus("r0_write", SEL_A, 16'h5555);
    applyStimulus("r2_bulk", SEL_B, 16'h0F0F);
    checkOutput();

    // Unknown write address while idle must not disturb state.
    wb_addr = 'x; wb_data = 16'hDEAD; rd_addr_b = 4'd1;
    nextEdge();
    applyStimulus("x_idle_r0", SEL_A, 16'h5555);
    applyStimulus("x_idle_r1", SEL_B, 16'h0042);
    applyStimulus("x_idle_cnt", SEL_CNT, 16'h0000);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_regfile_psr.md
Name: alu_regfile_psr

Overview:
- Register file and processor status register (PSR) stage around the 16-bit ALU.
- Upstream role: drives the ALU A/B operands from two asynchronous read ports.
- Downstream role: the ALU result C and the 5-bit ZCFNL flags come back through the write-back port and are committed on the clock edge.
- Sole architectural state holder for the datapath: 16 x 16-bit GPRs plus the PSR.

Parameters:
- DATA_W, 16, GPR and operand width.
- ADDR_W, 4, register address width; depth = 2**ADDR_W.
- FLAG_W, 5, PSR width. Bit order: 4=Z, 3=C, 2=F (overflow), 1=N, 0=L.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr_a  in  ADDR_W  read port A address.
- rd_addr_b  in  ADDR_W  read port B address.
- rd_data_a  out  DATA_W  GPR[rd_addr_a]; feeds ALU A.
- rd_data_b  out  DATA_W  GPR[rd_addr_b]; feeds ALU B.
- wb_we  in  1  write-back enable for GPR.
- wb_addr  in  ADDR_W  write-back destination.
- wb_data  in  DATA_W  write-back value (ALU C).
- wb_flag_we  in  1  PSR update enable.
- wb_flag_mask  in  FLAG_W  per-bit PSR update mask.
- wb_flags  in  FLAG_W  new flag values (ALU Flags).
- psr  out  FLAG_W  current PSR.
- wb_count  out  16  count of committed GPR writes (debug/perf).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- On rst_n low, immediately (no clock required): all GPRs = 16'h0000, psr = 5'b00000, wb_count = 0. Reads during reset return 0.
- Reads: combinational, zero latency.
  - rd_data_x = GPR[rd_addr_x] as of the last rising edge.
  - Both ports may read the same address.
- GPR write: at the rising clk edge when wb_we=1, GPR[wb_addr] <= wb_data.
  - All 16 registers are writable, including R0; there is no hardwired zero.
  - Visible on the read ports the cycle after the edge (without bypass).
- PSR write: at the rising edge when wb_flag_we=1, psr[i] <= wb_flags[i] for every i with wb_flag_mask[i]=1; all other bits hold.
  - Mask 5'b00000 with wb_flag_we=1 is a legal no-op.
- GPR and PSR enables are independent:
  - CMP uses flag-only writes (wb_we=0, wb_flag_we=1).
  - Logic ops use both.
- wb_count: increments by 1 at each edge with wb_we=1; wraps 16'hFFFF -> 0. PSR-only updates do not count.
- Simultaneous read and write of the same address in one cycle: the read returns the OLD value (unless BYPASS_EN is defined).
- rst_n asserted mid-cycle while wb_we=1: reset wins; the write is lost.
- rst_n deasserts synchronously to clk externally; the first write is accepted at the first edge after deassertion.
- X on wb_addr while wb_we=0 has no effect; the block must not propagate X into state.

Optional Feature:
- Macro: ALU_REGFILE_BYPASS_EN.
- Defined: combinational forwarding.
  - If wb_we=1 and rd_addr_x==wb_addr, then rd_data_x = wb_data in the same cycle.
  - psr output still shows the registered value; flags are not bypassed.
- Undefined: reads return stored values only; no comparators are synthesised.

Decomposition:
- Shared package alu_pkg:
  - DATA_W/ADDR_W/FLAG_W defaults.
  - Flag bit index constants FLAG_Z=4, FLAG_C=3, FLAG_F=2, FLAG_N=1, FLAG_L=0.
  - Common mask constants: MASK_ZONLY = 5'b10000, MASK_ALL = 5'b11111, MASK_NL = 5'b00011.
  - The ALU and decoder import the same package.
- One natural sub-module, psr_reg: masked 5-bit flag register with async active-low reset. Instantiated once here; reusable for an interrupt-save PSR copy.

Test Plan:
- Reset: assert rst_n=0 mid-simulation after writing R3=16'hBEEF -> rd_data_a(R3)=0, psr=0, wb_count=0 immediately, without a clock edge.
- Write/read: write R5=16'h1234, R15=16'hFFFF on consecutive edges; read A=R5, B=R15 -> 16'h1234 / 16'hFFFF the next cycle; wb_count=2.
- Same-cycle hazard: R7 holds 16'h0001; write R7=16'h00AA while reading R7 -> 16'h0001 without the macro, 16'h00AA with ALU_REGFILE_BYPASS_EN; 16'h00AA after the edge in both builds.
- Masked PSR: psr=5'b11111, then wb_flag_we=1, mask=5'b00011, flags=5'b00000 -> psr=5'b11100; then wb_flag_we=0, flags=5'b00011 -> psr unchanged.
- Independent enables: wb_we=0, wb_flag_we=1, mask=MASK_ALL, flags=5'b10000 -> psr=5'b10000, no GPR change, wb_count unchanged.
- Counter wrap: preload via 65535 writes, then one more write -> wb_count=0; R0 written with 16'h5555 reads back 16'h5555.
